// File: rtl/aes_stream_ctrl.sv
// Word-serial front/back end for the iterative AES-128 core: gathers four input
// words, optionally CBC-chains them, runs one block through the core, drains four words.
module aes_stream_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_we,
    input  logic [127:0] key_in,
    input  logic [127:0] iv_in,
    input  logic         mode_in,
    output logic         cfg_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out
);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_LOAD  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [1:0]   r_wcnt;
    logic [1:0]   r_ocnt;
    logic [127:0] r_blk;
    logic [127:0] r_chain;
    logic [127:0] r_obuf;
    logic [127:0] r_key;
    logic         r_mode;
    logic         r_cfg_err;

    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_cfg_ok;

    // Configuration is only safe between blocks, before any word of the next block.
    assign w_cfg_ok   = cfg_we && (r_state == S_FILL) && (r_wcnt == 2'd0);

    assign in_ready   = (r_state == S_FILL) && !cfg_we;
    assign out_valid  = (r_state == S_DRAIN);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign out_data     = r_obuf[127:96];
    assign busy         = (r_state != S_FILL);
    assign core_ld      = (r_state == S_LOAD);
    assign core_key     = r_key;
    assign core_text_in = r_mode ? (r_blk ^ r_chain) : r_blk;
    assign cfg_err      = r_cfg_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        unique case (r_state)
            S_FILL:  if (w_in_fire && (r_wcnt == 2'd3)) w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  if (core_done) w_next = S_DRAIN;
            S_DRAIN: if (w_out_fire && (r_ocnt == 2'd3)) w_next = S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt    <= 2'd0;
            r_ocnt    <= 2'd0;
            r_blk     <= '0;
            r_chain   <= '0;
            r_obuf    <= '0;
            r_key     <= '0;
            r_mode    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            r_cfg_err <= cfg_we && !w_cfg_ok;

            if (w_cfg_ok) begin
                r_key   <= key_in;
                r_chain <= iv_in;
                r_mode  <= mode_in;
            end

            if (w_in_fire) begin
                r_blk  <= {r_blk[95:0], in_data};
                r_wcnt <= r_wcnt + 2'd1;
            end

            // core_done is only trusted from WAIT onward; in LOAD it still shows idle.
            if ((r_state == S_WAIT) && core_done) begin
                r_obuf <= core_text_out;
                if (r_mode) begin
                    r_chain <= core_text_out;
                end
            end

            if (w_out_fire) begin
                r_obuf <= {r_obuf[95:0], 32'h0};
                r_ocnt <= r_ocnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Self-checking bench for aes_stream_ctrl with a cycle-timed behavioural AES core stand-in
// and a block-level reference model (key, chain, mode -> expected ciphertext).
module tb_aes_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_we = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] iv_in = '0;
    logic         mode_in = 1'b0;
    logic         cfg_err;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         busy;
    logic         core_ld;
    logic [127:0] core_key;
    logic [127:0] core_text_in;
    logic         core_done;
    logic [127:0] core_text_out;

    aes_stream_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .key_in        (key_in),
        .iv_in         (iv_in),
        .mode_in       (mode_in),
        .cfg_err       (cfg_err),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .busy          (busy),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_text_in  (core_text_in),
        .core_done     (core_done),
        .core_text_out (core_text_out)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_SP   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] IV_SP  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1_SP  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1_SP  = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2_SP  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2_SP  = 128'h5086cb9b507219ee95db113a917678b2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int first_valid_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Known-answer vectors stand in for real AES; any other input gets a keyed permutation.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] t);
        if (k == K_FIPS && t == P_FIPS) return C_FIPS;
        if (k == K_SP && t == (P1_SP ^ IV_SP)) return C1_SP;
        if (k == K_SP && t == (P2_SP ^ C1_SP)) return C2_SP;
        return {t[94:0], t[127:95]} ^ k ^ 128'hc3a5_5a3c_0ff0_9669_1234_8765_a5a5_3c3c;
    endfunction

    // Core: samples key/text on ld, done low for 11 cycles, result visible when done rises.
    logic [3:0]   core_cnt;
    logic [127:0] core_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt      <= 4'd0;
            core_done     <= 1'b1;
            core_text_out <= '0;
            core_res      <= '0;
        end else if (core_ld) begin
            core_cnt      <= 4'd11;
            core_done     <= 1'b0;
            core_res      <= aes_ref(core_key, core_text_in);
            core_text_out <= {4{32'hdeadbeef}};
        end else if (core_cnt == 4'd1) begin
            core_cnt      <= 4'd0;
            core_done     <= 1'b1;
            core_text_out <= core_res;
        end else if (core_cnt != 4'd0) begin
            core_cnt      <= core_cnt - 4'd1;
        end
    end

    // Reference model state: what the controller should hold after each config/block.
    logic [127:0] m_key = '0;
    logic [127:0] m_chain = '0;
    logic         m_mode = 1'b0;

    task automatic model_block(input logic [127:0] pt, output logic [127:0] ct);
        logic [127:0] x;
        x  = m_mode ? (pt ^ m_chain) : pt;
        ct = aes_ref(m_key, x);
        if (m_mode) m_chain = ct;
    endtask

    task automatic model_reset();
        m_key = '0;
        m_chain = '0;
        m_mode = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cfg(input logic [127:0] k, input logic [127:0] iv, input logic m,
                          input bit exp_ok, input bit with_valid, input string name);
        cfg_we = 1'b1;
        key_in = k;
        iv_in = iv;
        mode_in = m;
        if (with_valid) begin
            in_valid = 1'b1;
            in_data = 32'hbad00001;
        end
        @(negedge clk);
        if (with_valid) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s in_ready during cfg_we: got %b want 0", name, in_ready);
            end
        end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        in_valid = 1'b0;
        if (exp_ok) begin
            m_key = k;
            m_chain = iv;
            m_mode = m;
        end
        @(negedge clk);
        n_cmp++;
        if (cfg_err !== !exp_ok) begin
            n_bad++;
            $display("FAIL %s cfg_err: got %b want %b", name, cfg_err, !exp_ok);
        end
        n_cmp++;
        if (core_key !== m_key) begin
            n_bad++;
            $display("FAIL %s core_key: got %h want %h", name, core_key, m_key);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input string name);
        in_valid = 1'b1;
        in_data = w;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                last_acc_cyc = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL %s accept timeout: in_ready got 0 want 1", name);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] pt, input bit gaps, input string name);
        for (int i = 0; i < 4; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            send_word(pt[127-32*i -: 32], name);
        end
    endtask

    task automatic recv_word(output logic [31:0] d, input bit bp, input string name);
        logic        stalled;
        logic [31:0] held;
        stalled = 1'b0;
        held = '0;
        d = 'x;
        for (int n = 0; n < 200; n++) begin
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    n_bad++;
                    $display("FAIL %s stall hold: got v=%b d=%h want v=1 d=%h",
                             name, out_valid, out_data, held);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                d = out_data;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                return;
            end
            stalled = (out_valid === 1'b1);
            held = out_data;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL %s output timeout: out_valid got 0 want 1", name);
    endtask

    task automatic recv_block(input logic [127:0] exp, input bit bp, input bit chk_lat,
                              input string name);
        logic [31:0] w;
        first_valid_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            recv_word(w, bp, name);
            n_cmp++;
            if (w !== exp[127-32*i -: 32]) begin
                n_bad++;
                $display("FAIL %s word%0d: got %h want %h", name, i, w, exp[127-32*i -: 32]);
            end
        end
        if (chk_lat) begin
            n_cmp++;
            if (first_valid_cyc - last_acc_cyc != 14) begin
                n_bad++;
                $display("FAIL %s latency: got %0d want 14", name, first_valid_cyc - last_acc_cyc);
            end
        end
        // Cycle after the 4th output handshake: back in FILL, ready for input.
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL %s post-drain {in_ready,out_valid,busy}: got %b want 100",
                     name, {in_ready, out_valid, busy});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input logic [127:0] pt, input logic [127:0] exp, input bit gaps,
                             input bit bp, input bit chk_lat, input string name);
        send_block(pt, gaps, name);
        recv_block(exp, bp, chk_lat, name);
    endtask

    task automatic reset_pulse(input string name);
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({in_ready, out_valid, out_data, cfg_err, busy, core_ld, core_key, core_text_in} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 128'h0, 128'h0}) begin
            n_bad++;
            $display("FAIL %s outputs in reset: got rdy=%b v=%b d=%h err=%b busy=%b ld=%b key=%h txt=%h want 1/0/0/0/0/0/0/0",
                     name, in_ready, out_valid, out_data, cfg_err, busy, core_ld, core_key, core_text_in);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(1);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset cfg_err: got %b want 0", cfg_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (core_ld !== 1'b0) begin n_bad++; $display("FAIL reset core_ld: got %b want 0", core_ld); end
        n_cmp++; if (core_key !== 128'h0) begin n_bad++; $display("FAIL reset core_key: got %h want 0", core_key); end
        n_cmp++; if (core_text_in !== 128'h0) begin n_bad++; $display("FAIL reset core_text_in: got %h want 0", core_text_in); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_ecb_fips();
        do_cfg(K_FIPS, '0, 1'b0, 1'b1, 1'b0, "ecb_cfg");
        run_block(P_FIPS, C_FIPS, 1'b0, 1'b0, 1'b1, "ecb_fips");
    endtask

    task automatic test_cbc_sp800();
        logic [127:0] ct;
        do_cfg(K_SP, IV_SP, 1'b1, 1'b1, 1'b0, "cbc_cfg");
        model_block(P1_SP, ct);
        run_block(P1_SP, C1_SP, 1'b0, 1'b0, 1'b0, "cbc_blk1");
        model_block(P2_SP, ct);
        run_block(P2_SP, C2_SP, 1'b0, 1'b0, 1'b0, "cbc_blk2");
    endtask

    task automatic test_backpressure();
        do_cfg(K_FIPS, '0, 1'b0, 1'b1, 1'b0, "bp_cfg");
        for (int i = 0; i < 3; i++) run_block(P_FIPS, C_FIPS, 1'b1, 1'b1, 1'b0, "bp_fips");
    endtask

    task automatic test_cfg_err();
        logic [127:0] pt;
        logic [127:0] ct;
        do_cfg(K_FIPS, '0, 1'b0, 1'b1, 1'b0, "err_cfg");
        send_word(P_FIPS[127:96], "err_fill");
        send_word(P_FIPS[95:64], "err_fill");
        do_cfg(K_SP, IV_SP, 1'b1, 1'b0, 1'b0, "cfg_wcnt2");
        send_word(P_FIPS[63:32], "err_fill");
        send_word(P_FIPS[31:0], "err_fill");
        idle(1);
        do_cfg(K_SP, IV_SP, 1'b1, 1'b0, 1'b0, "cfg_wait");
        recv_block(C_FIPS, 1'b0, 1'b0, "err_old_key");
        do_cfg(K_SP, IV_SP, 1'b0, 1'b1, 1'b1, "cfg_with_valid");
        pt = rnd128();
        model_block(pt, ct);
        run_block(pt, ct, 1'b0, 1'b0, 1'b0, "after_cfg_valid");
    endtask

    task automatic test_reset_mid();
        do_cfg(K_SP, IV_SP, 1'b1, 1'b1, 1'b0, "rst_cfg");
        send_word(32'h01020304, "rst_fill");
        send_word(32'h05060708, "rst_fill");
        reset_pulse("rst_mid_fill");
        do_cfg(K_FIPS, '0, 1'b0, 1'b1, 1'b0, "rst_recfg1");
        run_block(P_FIPS, C_FIPS, 1'b0, 1'b0, 1'b0, "rst_fips1");
        send_block(P_FIPS, 1'b0, "rst_wait_fill");
        idle(3);
        reset_pulse("rst_mid_wait");
        do_cfg(K_FIPS, '0, 1'b0, 1'b1, 1'b0, "rst_recfg2");
        run_block(P_FIPS, C_FIPS, 1'b0, 1'b0, 1'b1, "rst_fips2");
    endtask

    task automatic test_reconfig_iv();
        logic [127:0] pt;
        logic [127:0] ct;
        do_cfg(K_SP, rnd128(), 1'b1, 1'b1, 1'b0, "iv_cfg_a");
        pt = rnd128();
        model_block(pt, ct);
        run_block(pt, ct, 1'b0, 1'b0, 1'b0, "iv_blk_a");
        do_cfg(K_SP, rnd128(), 1'b1, 1'b1, 1'b0, "iv_cfg_b");
        pt = rnd128();
        model_block(pt, ct);
        run_block(pt, ct, 1'b0, 1'b0, 1'b0, "iv_blk_b");
    endtask

    task automatic test_random();
        logic [127:0] pt;
        logic [127:0] ct;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || $urandom_range(0, 2) == 0)
                do_cfg(rnd128(), rnd128(), ($urandom_range(0, 1) == 1), 1'b1, 1'b0, "rnd_cfg");
            pt = rnd128();
            model_block(pt, ct);
            run_block(pt, ct, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, "rnd_blk");
        end
    endtask

    initial begin
        test_reset();
        test_ecb_fips();
        test_cbc_sp800();
        test_backpressure();
        test_cfg_err();
        test_reset_mid();
        test_reconfig_iv();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
